// File: rtl/fcp_pkg.sv
// Shared state encoding, command bytes and default timing for the FCP master transmitter.
package fcp_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PING0 = 3'd1,
        GAP   = 3'd2,
        SYNC  = 3'd3,
        BITS  = 3'd4,
        PING1 = 3'd5,
        IFS   = 3'd6
    } fcp_state_t;

    localparam logic [7:0] SBRWR = 8'h0B;
    localparam logic [7:0] SBRRD = 8'h0C;

    localparam int DEF_CLK_PER_UI = 16;
    localparam int DEF_PING_UI    = 16;
    localparam int DEF_GAP_UI     = 25;
    localparam int DEF_IFS_UI     = 100;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Odd parity over the 9 transmitted bits (8 data + P).
    function automatic logic odd_par(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/fcp_qtick.sv
// Quarter-UI tick generator: modulo-Q counter, held at zero while restart is high.
module fcp_qtick #(
    parameter int Q = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_restart,
    output logic o_tick
);

    localparam int W = (Q > 1) ? $clog2(Q) : 1;

    logic [W-1:0] r_cnt;

    assign o_tick = !i_restart && (r_cnt == W'(Q - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_restart || o_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + W'(1);
        end
    end

endmodule

// File: rtl/fcp_mst_tx.sv
// FCP single-wire master transmitter: frames a byte stream into ping, gap, sync/data/parity
// groups, trailing ping and inter-frame spacing; all line timing counted in quarter-UIs.
module fcp_mst_tx
    import fcp_pkg::*;
#(
    parameter int CLK_PER_UI = DEF_CLK_PER_UI,
    parameter int PING_UI    = DEF_PING_UI,
    parameter int GAP_UI     = DEF_GAP_UI,
    parameter int IFS_UI     = DEF_IFS_UI
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       s_valid,
    input  logic [7:0] s_data,
    input  logic       s_last,
    output logic       s_ready,
    output logic       line_o,
    output logic       line_oe,
    output logic       busy,
    output logic       done,
    output logic       err,
    output fcp_state_t o_dbg_state
);

    localparam int Q     = CLK_PER_UI / 4;
    localparam int MAX_Q = 4 * max_int(max_int(PING_UI, GAP_UI), max_int(IFS_UI, 9));
    localparam int QW    = $clog2(MAX_Q);

    localparam logic [QW-1:0] PING_LQ = QW'(PING_UI * 4 - 1);
    localparam logic [QW-1:0] GAP_LQ  = QW'(GAP_UI * 4 - 1);
    localparam logic [QW-1:0] IFS_LQ  = QW'(IFS_UI * 4 - 1);
    localparam logic [QW-1:0] BYTE_LQ = QW'(9 * 4 - 1);

    fcp_state_t    r_state, w_state_nxt;
    logic [QW-1:0] r_qcnt, w_qcnt_nxt;
    logic [8:0]    r_shift, w_shift_nxt;
    logic          r_last, w_last_nxt;
    logic          r_prev, w_prev_nxt;
    logic          r_three, w_three_nxt;
    logic          r_final, w_final_nxt;
    logic          r_under, w_under_nxt;
    logic          r_line, w_line_nxt;
    logic          r_oe, w_oe_nxt;
    logic          r_done, w_done_nxt;
    logic          r_err, w_err_nxt;
    logic          w_take;
    logic          w_tick;
    logic          w_ui_end;

    fcp_qtick #(
        .Q(Q)
    ) u_qtick (
        .clk      (clk),
        .rst      (rst),
        .i_restart(r_state == IDLE),
        .o_tick   (w_tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_qcnt  <= '0;
            r_shift <= '0;
            r_last  <= 1'b0;
            r_prev  <= 1'b0;
            r_three <= 1'b0;
            r_final <= 1'b0;
            r_under <= 1'b0;
            r_line  <= 1'b0;
            r_oe    <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_qcnt  <= w_qcnt_nxt;
            r_shift <= w_shift_nxt;
            r_last  <= w_last_nxt;
            r_prev  <= w_prev_nxt;
            r_three <= w_three_nxt;
            r_final <= w_final_nxt;
            r_under <= w_under_nxt;
            r_line  <= w_line_nxt;
            r_oe    <= w_oe_nxt;
            r_done  <= w_done_nxt;
            r_err   <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_qcnt_nxt  = r_qcnt;
        w_shift_nxt = r_shift;
        w_last_nxt  = r_last;
        w_prev_nxt  = r_prev;
        w_three_nxt = r_three;
        w_final_nxt = r_final;
        w_under_nxt = r_under;
        w_done_nxt  = 1'b0;
        w_err_nxt   = 1'b0;
        w_take      = 1'b0;
        w_ui_end    = w_tick && (r_qcnt[1:0] == 2'd3);

        if (w_tick) begin
            w_qcnt_nxt = r_qcnt + QW'(1);
        end

        case (r_state)
            IDLE: begin
                w_qcnt_nxt = '0;
                if (s_valid) begin
                    w_take      = 1'b1;
                    w_under_nxt = 1'b0;
                    w_state_nxt = PING0;
                end
            end
            PING0: begin
                if (w_tick && r_qcnt == PING_LQ) begin
                    w_state_nxt = GAP;
                    w_qcnt_nxt  = '0;
                end
            end
            GAP: begin
                // First sync of a frame behaves as if the previous bit were 0.
                if (w_tick && r_qcnt == GAP_LQ) begin
                    w_state_nxt = SYNC;
                    w_qcnt_nxt  = '0;
                    w_prev_nxt  = 1'b0;
                    w_three_nxt = ~r_shift[8];
                    w_final_nxt = 1'b0;
                end
            end
            SYNC: begin
                if (w_tick && r_qcnt == (r_three ? QW'(2) : QW'(1))) begin
                    w_state_nxt = r_final ? PING1 : BITS;
                    w_qcnt_nxt  = '0;
                end
            end
            BITS: begin
                if (w_tick && r_qcnt == BYTE_LQ) begin
                    // r_shift[8] holds P here; an underflow closes the frame like a last byte.
                    w_state_nxt = SYNC;
                    w_qcnt_nxt  = '0;
                    w_prev_nxt  = r_shift[8];
                    if (!r_last && s_valid) begin
                        w_take      = 1'b1;
                        w_three_nxt = (r_shift[8] == s_data[7]);
                        w_final_nxt = 1'b0;
                    end else begin
                        w_three_nxt = r_shift[8];
                        w_final_nxt = 1'b1;
                        w_under_nxt = !r_last;
                    end
                end else if (w_ui_end) begin
                    w_shift_nxt = {r_shift[7:0], 1'b0};
                end
            end
            PING1: begin
                if (w_tick && r_qcnt == PING_LQ) begin
                    w_state_nxt = IFS;
                    w_qcnt_nxt  = '0;
                    w_done_nxt  = 1'b1;
                    w_err_nxt   = r_under;
                end
            end
            IFS: begin
                // A waiting byte in the final IFS cycle starts the next frame with no idle gap.
                if (w_tick && r_qcnt == IFS_LQ) begin
                    w_qcnt_nxt = '0;
                    if (s_valid) begin
                        w_take      = 1'b1;
                        w_under_nxt = 1'b0;
                        w_state_nxt = PING0;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_qcnt_nxt  = '0;
            end
        endcase

        if (w_take) begin
            w_shift_nxt = {s_data, odd_par(s_data)};
            w_last_nxt  = s_last;
        end

        w_oe_nxt   = 1'b0;
        w_line_nxt = 1'b0;
        case (w_state_nxt)
            PING0, PING1: begin
                w_oe_nxt   = 1'b1;
                w_line_nxt = 1'b1;
            end
            SYNC: begin
                w_oe_nxt   = 1'b1;
                w_line_nxt = ~w_prev_nxt ^ w_qcnt_nxt[0];
            end
            BITS: begin
                w_oe_nxt   = 1'b1;
                w_line_nxt = w_shift_nxt[8];
            end
            default: begin
                w_oe_nxt   = 1'b0;
                w_line_nxt = 1'b0;
            end
        endcase
    end

    assign s_ready     = w_take && !rst;
    assign busy        = !rst && ((r_state != IDLE) || w_take);
    assign line_o      = r_line;
    assign line_oe     = r_oe;
    assign done        = r_done;
    assign err         = r_err;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_fcp_mst_tx.sv
// Directed bench for fcp_mst_tx: per-cycle comparison of line, handshake and status outputs
// against an expected waveform queue built from the frame contents.
module tb_fcp_mst_tx;
    import fcp_pkg::*;

    localparam int CPU    = 16;
    localparam int QC     = CPU / 4;
    localparam int PING_C = 16 * CPU;
    localparam int GAP_C  = 25 * CPU;
    localparam int IFS_C  = 100 * CPU;

    logic       clk = 1'b0;
    logic       rst;
    logic       s_valid;
    logic [7:0] s_data;
    logic       s_last;
    logic       s_ready;
    logic       line_o;
    logic       line_oe;
    logic       busy;
    logic       done;
    logic       err;
    fcp_state_t o_dbg_state;

    int checks   = 0;
    int failures = 0;

    logic [1:0] exp_q[$];
    int         rdy_q[$];
    int         done_idx;
    logic [7:0] fr[8];
    logic [7:0] nf0;
    logic       nf_last;

    fcp_mst_tx #(
        .CLK_PER_UI(CPU),
        .PING_UI   (16),
        .GAP_UI    (25),
        .IFS_UI    (100)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_last     (s_last),
        .s_ready    (s_ready),
        .line_o     (line_o),
        .line_oe    (line_oe),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .o_dbg_state(o_dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic obs, input logic expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    task automatic push_n(input logic oe, input logic lv, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back({oe, lv});
    endtask

    task automatic push_sync(input logic prev, input logic nxt);
        int   np;
        logic lv;
        np = (prev == nxt) ? 3 : 2;
        lv = ~prev;
        for (int k = 0; k < np; k++) begin
            push_n(1'b1, lv, QC);
            lv = ~lv;
        end
    endtask

    // Expected line waveform from the first leading-ping cycle to the last IFS cycle.
    task automatic build_exp(input int n, input bit b2b);
        logic       prev;
        logic       p;
        logic [7:0] b;
        exp_q.delete();
        rdy_q.delete();
        push_n(1'b1, 1'b1, PING_C);
        push_n(1'b0, 1'b0, GAP_C);
        prev = 1'b0;
        for (int i = 0; i < n; i++) begin
            b = fr[i];
            push_sync(prev, b[7]);
            for (int k = 7; k >= 0; k--) push_n(1'b1, b[k], CPU);
            p = ~^b;
            push_n(1'b1, p, CPU);
            prev = p;
            if (i < n - 1) rdy_q.push_back(exp_q.size() - 1);
        end
        push_sync(prev, 1'b1);
        push_n(1'b1, 1'b1, PING_C);
        done_idx = exp_q.size();
        push_n(1'b0, 1'b0, IFS_C);
        if (b2b) rdy_q.push_back(exp_q.size() - 1);
    endtask

    task automatic drive_next(input int bi, input int n, input bit under, input bit b2b);
        if (bi < n && !under) begin
            s_valid = 1'b1;
            s_data  = fr[bi];
            s_last  = (bi == n - 1);
        end else if (b2b) begin
            s_valid = 1'b1;
            s_data  = nf0;
            s_last  = nf_last;
        end else begin
            s_valid = 1'b0;
            s_data  = 8'h00;
            s_last  = 1'b0;
        end
    endtask

    task automatic send_frame(input string name, input int n, input bit under,
                              input bit b2b, input bit pre_started);
        int   bi;
        int   f0;
        bit   bad;
        logic got_rdy;
        logic exp_rdy;
        build_exp(n, b2b);
        if (!pre_started) begin
            s_valid = 1'b1;
            s_data  = fr[0];
            s_last  = (n == 1) && !under;
            @(negedge clk);
            check({name, "_start_ready"}, s_ready, 1'b1);
            check({name, "_start_busy"}, busy, 1'b1);
            @(posedge clk); #1;
        end
        bi = 1;
        drive_next(bi, n, under, b2b);
        bad = 1'b0;
        for (int idx = 0; idx < exp_q.size(); idx++) begin
            @(negedge clk);
            got_rdy = s_ready;
            exp_rdy = (rdy_q.size() != 0 && rdy_q[0] == idx);
            if (exp_rdy) void'(rdy_q.pop_front());
            if (!bad) begin
                f0 = failures;
                check({name, "_line_oe"}, line_oe, exp_q[idx][1]);
                if (exp_q[idx][1]) check({name, "_line_o"}, line_o, exp_q[idx][0]);
                check({name, "_s_ready"}, s_ready, exp_rdy);
                check({name, "_done"}, done, idx == done_idx);
                check({name, "_err"}, err, under && (idx == done_idx));
                check({name, "_busy"}, busy, 1'b1);
                if (failures != f0) begin
                    bad = 1'b1;
                    $display("  %s: first deviation at cycle %0d of frame", name, idx);
                end
            end
            @(posedge clk); #1;
            if (got_rdy && bi < n) begin
                bi++;
                drive_next(bi, n, under, b2b);
            end
        end
    endtask

    initial begin
        rst     = 1'b1;
        s_valid = 1'b0;
        s_data  = 8'h00;
        s_last  = 1'b0;
        nf0     = 8'h00;
        nf_last = 1'b0;
        for (int i = 0; i < 8; i++) fr[i] = 8'h00;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_line_o", line_o, 1'b0);
        check("rst_line_oe", line_oe, 1'b0);
        check("rst_s_ready", s_ready, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_err", err, 1'b0);
        checks++;
        assert (o_dbg_state === IDLE) else begin
            failures++;
            $error("FAIL rst_state observed=%0d expected=%0d", o_dbg_state, IDLE);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Single byte 0x01: sync 1,0,1; P=0; trailing sync 1,0
        fr[0] = 8'h01;
        send_frame("one_byte", 1, 1'b0, 1'b0, 1'b0);

        // 0x0C then 0x04: inter-byte sync 0,1; ready at end of 0x0C parity UI
        fr[0] = SBRRD;
        fr[1] = 8'h04;
        send_frame("two_byte", 2, 1'b0, 1'b0, 1'b0);

        // Four bytes with two 3-pulse inter-byte syncs
        fr[0] = SBRWR;
        fr[1] = 8'h2C;
        fr[2] = 8'h5A;
        fr[3] = 8'h34;
        send_frame("four_byte", 4, 1'b0, 1'b0, 1'b0);

        // Underflow: 0x0C without last, source empty afterwards
        fr[0] = SBRRD;
        send_frame("underflow", 1, 1'b1, 1'b0, 1'b0);

        // Back-to-back: second frame waiting through IFS
        fr[0]   = 8'hA5;
        nf0     = 8'h3C;
        nf_last = 1'b1;
        send_frame("b2b_first", 1, 1'b0, 1'b1, 1'b0);
        fr[0] = 8'h3C;
        send_frame("b2b_second", 1, 1'b0, 1'b0, 1'b1);

        @(negedge clk);
        check("idle_busy", busy, 1'b0);
        check("idle_oe", line_oe, 1'b0);
        @(posedge clk); #1;

        // Reset in the middle of the data bits
        s_valid = 1'b1;
        s_data  = 8'hC3;
        s_last  = 1'b1;
        @(negedge clk);
        check("mid_start_ready", s_ready, 1'b1);
        @(posedge clk); #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
        repeat (PING_C + GAP_C + 3 * QC + 20) @(posedge clk);
        #1;
        check("mid_oe_before", line_oe, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("mid_oe_async", line_oe, 1'b0);
        check("mid_busy", busy, 1'b0);
        check("mid_done", done, 1'b0);
        check("mid_err", err, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("mid_hold_done", done, 1'b0);
            check("mid_hold_oe", line_oe, 1'b0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        fr[0] = 8'h96;
        send_frame("after_rst", 1, 1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
